insn_buffer_rvc: RTL and testbench
==================================

Name: insn_buffer_rvc

Overview:
- Parametrised successor to the single-halfword instruction buffer entry scheme: a circular FIFO of 16-bit halfword entries sitting between the fetch stage and decode.
- Accepts up to FETCH_HALVES halfwords per cycle, each carrying PC, fault and interrupt tags.
- Emits one complete instruction per cycle: a 16-bit RVC instruction from one entry, or a 32-bit instruction reassembled from two entries that may arrive in different fetch beats.
- Supports synchronous flush for branch redirect and trap.

Parameters:
ENTRY_COUNT, 8, number of halfword entries; power of 2, >= 2*FETCH_HALVES
FETCH_HALVES, 2, halfword lanes written per enqueue beat
ADDR_WIDTH, 32, PC width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
flush  in  1  discard all contents this cycle
enqueueValid  in  1  fetch beat present
enqueueReady  out  1  buffer can take a full beat
enqueueCount  in  $clog2(FETCH_HALVES)+1  halfwords valid in beat (1..FETCH_HALVES, low lanes)
enqueuePc  in  ADDR_WIDTH  PC of lane 0; lane i PC = enqueuePc + 2*i
enqueueInsn  in  16*FETCH_HALVES  lane i at bits [16i+15:16i]
enqueueFault  in  1  fetch fault; tags every lane of the beat
enqueueInterruptValid  in  1  interrupt pending; tags lane 0 only
enqueueInterruptCode  in  4  interrupt code for lane 0
dequeueValid  out  1  complete instruction available
dequeueReady  in  1  decode accepts
dequeuePc  out  ADDR_WIDTH  PC of first halfword
dequeueInsn  out  32  instruction; upper 16 bits are 0 when compressed
dequeueCompressed  out  1  1 = 16-bit instruction
dequeueFault  out  1  OR of fault tags of consumed entries
dequeueInterruptValid  out  1  OR of interrupt tags of consumed entries
dequeueInterruptCode  out  4  code of lowest consumed entry with interrupt tag; 0 if none
entryCount  out  $clog2(ENTRY_COUNT)+1  occupied entries

Behaviour:
- Reset (async, any time, including mid-operation): head = tail = count = 0.
  - After reset: dequeueValid = 0, enqueueReady = 1, entryCount = 0.
  - Entry storage need not be reset; all data outputs are 0 while dequeueValid = 0.
- enqueueReady = !flush && (ENTRY_COUNT - count >= FETCH_HALVES).
  - Computed from the registered count only; no same-cycle dequeue bypass.
- Enqueue fires when enqueueValid && enqueueReady.
  - Writes enqueueCount entries at tail, tail+1, ... (mod ENTRY_COUNT); tail advances by enqueueCount.
  - enqueueCount outside 1..FETCH_HALVES is illegal; the bench asserts on it.
- Written entries are visible at the dequeue side the next cycle (1-cycle latency). Dequeue outputs are combinational from head entries and count.
- Head classification, E0 = entry[head]:
  - Single-entry consume if E0.insn[1:0] != 2'b11, or E0.fault, or E0.interruptValid.
    - dequeueValid = (count >= 1).
    - dequeueCompressed = 1 only if E0.insn[1:0] != 2'b11; otherwise the faulted or interrupted half is emitted alone with dequeueCompressed = 0.
  - Otherwise two-entry consume of E0 and E1 = entry[head+1].
    - dequeueValid = (count >= 2).
    - dequeueInsn = {E1.insn, E0.insn}; dequeueFault = E0.fault | E1.fault.
    - Interrupt outputs are taken from E1 if tagged.
  - dequeuePc is always E0.pc.
- Dequeue fires when dequeueValid && dequeueReady && !flush; head advances by 1 or 2.
- Count update: count_next = count + enq_n - deq_n. Simultaneous enqueue and dequeue are legal in the same cycle.
- Wrap-around: pointers are $clog2(ENTRY_COUNT) bits and wrap naturally. A 32-bit pair may straddle index ENTRY_COUNT-1 -> 0.
- Flush (synchronous, priority over enqueue and dequeue):
  - Next cycle head = tail = count = 0.
  - Same-cycle enqueue and dequeue are discarded.
  - dequeueValid is 0 in the cycle after flush.
- dequeueValid must not drop without a dequeue or flush once asserted. Outputs stay stable while valid && !ready.

Test Plan:
- Reset, enqueue count=2, pc=0x80000000, lanes {0x0010, 0x0093} -> next cycle dequeueValid=1, dequeueInsn=0x00100093, dequeueCompressed=0, dequeuePc=0x80000000; after dequeue entryCount=0.
- Enqueue count=2, pc=0x80000004, lane0=0x4505, lane1=0x4585 -> two dequeues: (0x00004505, pc 0x80000004, compressed=1), then (0x00004585, pc 0x80000006).
- Split 32-bit: enqueue count=1 lane0=0x0093 -> dequeueValid stays 0, entryCount=1; enqueue count=1 lane0=0x0010 -> next cycle dequeueValid=1, insn 0x00100093.
- Full and wrap: ENTRY_COUNT=8, 4 beats of count=2 with dequeueReady=0 -> entryCount=8, enqueueReady=0; dequeue one 32-bit -> entryCount=6, enqueueReady=1. Refill to 8 and dequeue across the wrap; the pair at entries 7/0 reassembles correctly.
- Fault and interrupt: enqueue count=2 with fault=1, lane0=0x0093 -> dequeue of 1 entry, dequeueFault=1, dequeueCompressed=0, entryCount 2->1. Enqueue with interruptValid=1, code=7 -> dequeueInterruptValid=1, code=7.
- Flush mid-operation: entryCount=5, assert flush together with enqueueValid and dequeueReady -> next cycle entryCount=0, dequeueValid=0. Async rst pulse mid-burst -> outputs return to reset values immediately.

Source files
------------

// File: rtl/insn_buffer_rvc.sv
// Halfword instruction buffer between fetch and decode. Buffers tagged 16-bit
// fetch lanes in a circular FIFO and emits one RVC or reassembled 32-bit insn per cycle.
module insn_buffer_rvc #(
  parameter int ENTRY_COUNT  = 8,
  parameter int FETCH_HALVES = 2,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              enqueueValid,
  output logic                              enqueueReady,
  input  logic [$clog2(FETCH_HALVES):0]     enqueueCount,
  input  logic [ADDR_WIDTH-1:0]             enqueuePc,
  input  logic [16*FETCH_HALVES-1:0]        enqueueInsn,
  input  logic                              enqueueFault,
  input  logic                              enqueueInterruptValid,
  input  logic [3:0]                        enqueueInterruptCode,
  output logic                              dequeueValid,
  input  logic                              dequeueReady,
  output logic [ADDR_WIDTH-1:0]             dequeuePc,
  output logic [31:0]                       dequeueInsn,
  output logic                              dequeueCompressed,
  output logic                              dequeueFault,
  output logic                              dequeueInterruptValid,
  output logic [3:0]                        dequeueInterruptCode,
  output logic [$clog2(ENTRY_COUNT):0]      entryCount
);

  localparam int PTR_W = $clog2(ENTRY_COUNT);
  localparam int CNT_W = PTR_W + 1;
  localparam int ECW   = $clog2(FETCH_HALVES) + 1;

  logic [15:0]           insn_mem_r  [ENTRY_COUNT];
  logic [ADDR_WIDTH-1:0] pc_mem_r    [ENTRY_COUNT];
  logic                  fault_mem_r [ENTRY_COUNT];
  logic                  irq_mem_r   [ENTRY_COUNT];
  logic [3:0]            code_mem_r  [ENTRY_COUNT];

  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;

  logic [PTR_W-1:0] wr_idx_s [FETCH_HALVES];
  logic             wr_en_s  [FETCH_HALVES];
  logic [PTR_W-1:0] head1_s;
  logic [CNT_W-1:0] free_s;
  logic [CNT_W-1:0] enq_n_s;
  logic [CNT_W-1:0] deq_n_s;
  logic             e0_rvc_s;
  logic             single_s;
  logic             deq_valid_s;
  logic             enq_fire_s;
  logic             deq_fire_s;

  // Readiness is judged from the registered occupancy only; flush blocks intake.
  always_comb begin
    free_s       = CNT_W'(ENTRY_COUNT) - count_r;
    enqueueReady = !flush && (free_s >= CNT_W'(FETCH_HALVES));
    enq_fire_s   = enqueueValid && enqueueReady;
    enq_n_s      = enq_fire_s ? CNT_W'(enqueueCount) : {CNT_W{1'b0}};
  end

  // Per-lane write slot and enable; only the low enqueueCount lanes are stored.
  always_comb begin
    for (int i = 0; i < FETCH_HALVES; i++) begin
      wr_idx_s[i] = tail_r + PTR_W'(i);
      wr_en_s[i]  = enq_fire_s && (ECW'(i) < enqueueCount);
    end
  end

  // Entry storage; contents are qualified by count so they carry no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_HALVES; i++) begin
      if (wr_en_s[i]) begin
        insn_mem_r[wr_idx_s[i]]  <= enqueueInsn[16*i +: 16];
        pc_mem_r[wr_idx_s[i]]    <= enqueuePc + ADDR_WIDTH'(2 * i);
        fault_mem_r[wr_idx_s[i]] <= enqueueFault;
        // The interrupt belongs to the first halfword of the beat only.
        irq_mem_r[wr_idx_s[i]]   <= (i == 0) ? enqueueInterruptValid : 1'b0;
        code_mem_r[wr_idx_s[i]]  <= (i == 0) ? enqueueInterruptCode : 4'h0;
      end
    end
  end

  // Head classification: a faulted or interrupted half is always emitted alone.
  always_comb begin
    head1_s  = head_r + PTR_W'(1);
    e0_rvc_s = (insn_mem_r[head_r][1:0] != 2'b11);
    single_s = e0_rvc_s || fault_mem_r[head_r] || irq_mem_r[head_r];
    if (single_s) begin
      deq_valid_s = (count_r >= CNT_W'(1));
    end else begin
      deq_valid_s = (count_r >= CNT_W'(2));
    end
    deq_fire_s = deq_valid_s && dequeueReady && !flush;
    if (deq_fire_s) begin
      deq_n_s = single_s ? CNT_W'(1) : CNT_W'(2);
    end else begin
      deq_n_s = {CNT_W{1'b0}};
    end
  end

  // Dequeue payload; every data output is forced to zero while not valid.
  always_comb begin
    dequeueValid          = deq_valid_s;
    dequeuePc             = {ADDR_WIDTH{1'b0}};
    dequeueInsn           = 32'h0000_0000;
    dequeueCompressed     = 1'b0;
    dequeueFault          = 1'b0;
    dequeueInterruptValid = 1'b0;
    dequeueInterruptCode  = 4'h0;
    if (deq_valid_s) begin
      dequeuePc = pc_mem_r[head_r];
      if (single_s) begin
        dequeueInsn           = {16'h0000, insn_mem_r[head_r]};
        dequeueCompressed     = e0_rvc_s;
        dequeueFault          = fault_mem_r[head_r];
        dequeueInterruptValid = irq_mem_r[head_r];
        dequeueInterruptCode  = irq_mem_r[head_r] ? code_mem_r[head_r] : 4'h0;
      end else begin
        // E0 carries no interrupt here, so only E1 can supply one.
        dequeueInsn           = {insn_mem_r[head1_s], insn_mem_r[head_r]};
        dequeueCompressed     = 1'b0;
        dequeueFault          = fault_mem_r[head_r] | fault_mem_r[head1_s];
        dequeueInterruptValid = irq_mem_r[head1_s];
        dequeueInterruptCode  = irq_mem_r[head1_s] ? code_mem_r[head1_s] : 4'h0;
      end
    end else begin
      dequeuePc = {ADDR_WIDTH{1'b0}};
    end
  end

  // Pointer and occupancy state; flush wins over both enqueue and dequeue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (flush) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      head_r  <= head_r + deq_n_s[PTR_W-1:0];
      tail_r  <= tail_r + enq_n_s[PTR_W-1:0];
      count_r <= count_r + enq_n_s - deq_n_s;
    end
  end

  assign entryCount = count_r;

endmodule

// File: tb/tb_insn_buffer_rvc.sv
// Directed bench for insn_buffer_rvc (ENTRY_COUNT=8, FETCH_HALVES=2):
// each task drives a scenario and compares outputs against hand-derived values.
module tb_insn_buffer_rvc;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        enqueueValid;
  logic        enqueueReady;
  logic [1:0]  enqueueCount;
  logic [31:0] enqueuePc;
  logic [31:0] enqueueInsn;
  logic        enqueueFault;
  logic        enqueueInterruptValid;
  logic [3:0]  enqueueInterruptCode;
  logic        dequeueValid;
  logic        dequeueReady;
  logic [31:0] dequeuePc;
  logic [31:0] dequeueInsn;
  logic        dequeueCompressed;
  logic        dequeueFault;
  logic        dequeueInterruptValid;
  logic [3:0]  dequeueInterruptCode;
  logic [3:0]  entryCount;

  int vecs  = 0;
  int fails = 0;

  insn_buffer_rvc #(.ENTRY_COUNT(8), .FETCH_HALVES(2), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enqueueValid(enqueueValid), .enqueueReady(enqueueReady), .enqueueCount(enqueueCount),
    .enqueuePc(enqueuePc), .enqueueInsn(enqueueInsn), .enqueueFault(enqueueFault),
    .enqueueInterruptValid(enqueueInterruptValid), .enqueueInterruptCode(enqueueInterruptCode),
    .dequeueValid(dequeueValid), .dequeueReady(dequeueReady), .dequeuePc(dequeuePc),
    .dequeueInsn(dequeueInsn), .dequeueCompressed(dequeueCompressed), .dequeueFault(dequeueFault),
    .dequeueInterruptValid(dequeueInterruptValid), .dequeueInterruptCode(dequeueInterruptCode),
    .entryCount(entryCount)
  );

  always #5 clk = ~clk;

  // Illegal beat sizes must never be offered to the buffer.
  always @(posedge clk) begin
    if (!rst && enqueueValid && enqueueReady)
      assert (enqueueCount >= 2'd1 && enqueueCount <= 2'd2)
        else $error("illegal enqueueCount %0d", enqueueCount);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic enq(input logic [1:0] cnt, input logic [31:0] pc, input logic [31:0] insn,
                     input logic flt, input logic iv, input logic [3:0] code);
    enqueueValid = 1'b1; enqueueCount = cnt; enqueuePc = pc; enqueueInsn = insn;
    enqueueFault = flt; enqueueInterruptValid = iv; enqueueInterruptCode = code;
    tick();
    enqueueValid = 1'b0; enqueueFault = 1'b0; enqueueInterruptValid = 1'b0; enqueueInterruptCode = 4'h0;
  endtask

  task automatic deq1();
    dequeueReady = 1'b1;
    tick();
    dequeueReady = 1'b0;
  endtask

  task automatic test_reset();
    vecs++; if ({dequeueValid, enqueueReady, entryCount} !== {1'b0, 1'b1, 4'd0}) begin
      fails++; $display("FAIL reset_state: got v=%b r=%b cnt=%0d exp v=0 r=1 cnt=0", dequeueValid, enqueueReady, entryCount); end
    vecs++; if ({dequeueInsn, dequeuePc} !== 64'h0) begin
      fails++; $display("FAIL reset_data: got insn=%h pc=%h exp 0", dequeueInsn, dequeuePc); end
  endtask

  task automatic test_basic_32();
    enq(2'd2, 32'h8000_0000, 32'h0010_0093, 1'b0, 1'b0, 4'h0);
    vecs++; if ({dequeueValid, dequeueCompressed, dequeueInsn, dequeuePc, entryCount} !== {1'b1, 1'b0, 32'h0010_0093, 32'h8000_0000, 4'd2}) begin
      fails++; $display("FAIL basic32_out: got v=%b c=%b insn=%h pc=%h cnt=%0d exp v=1 c=0 insn=00100093 pc=80000000 cnt=2",
                        dequeueValid, dequeueCompressed, dequeueInsn, dequeuePc, entryCount); end
    deq1();
    vecs++; if ({dequeueValid, entryCount} !== {1'b0, 4'd0}) begin
      fails++; $display("FAIL basic32_drain: got v=%b cnt=%0d exp v=0 cnt=0", dequeueValid, entryCount); end
  endtask

  task automatic test_rvc_pair();
    enq(2'd2, 32'h8000_0004, 32'h4585_4505, 1'b0, 1'b0, 4'h0);
    vecs++; if ({dequeueValid, dequeueCompressed, dequeueInsn, dequeuePc} !== {1'b1, 1'b1, 32'h0000_4505, 32'h8000_0004}) begin
      fails++; $display("FAIL rvc_first: got v=%b c=%b insn=%h pc=%h exp v=1 c=1 insn=00004505 pc=80000004",
                        dequeueValid, dequeueCompressed, dequeueInsn, dequeuePc); end
    deq1();
    vecs++; if ({dequeueValid, dequeueCompressed, dequeueInsn, dequeuePc, entryCount} !== {1'b1, 1'b1, 32'h0000_4585, 32'h8000_0006, 4'd1}) begin
      fails++; $display("FAIL rvc_second: got v=%b c=%b insn=%h pc=%h cnt=%0d exp v=1 c=1 insn=00004585 pc=80000006 cnt=1",
                        dequeueValid, dequeueCompressed, dequeueInsn, dequeuePc, entryCount); end
    deq1();
    vecs++; if ({dequeueValid, entryCount} !== {1'b0, 4'd0}) begin
      fails++; $display("FAIL rvc_drain: got v=%b cnt=%0d exp v=0 cnt=0", dequeueValid, entryCount); end
  endtask

  task automatic test_split_32();
    enq(2'd1, 32'h8000_000a, 32'h0000_0093, 1'b0, 1'b0, 4'h0);
    vecs++; if ({dequeueValid, entryCount} !== {1'b0, 4'd1}) begin
      fails++; $display("FAIL split_half: got v=%b cnt=%0d exp v=0 cnt=1", dequeueValid, entryCount); end
    enq(2'd1, 32'h8000_000c, 32'h0000_0010, 1'b0, 1'b0, 4'h0);
    vecs++; if ({dequeueValid, dequeueCompressed, dequeueInsn, dequeuePc, entryCount} !== {1'b1, 1'b0, 32'h0010_0093, 32'h8000_000a, 4'd2}) begin
      fails++; $display("FAIL split_join: got v=%b c=%b insn=%h pc=%h cnt=%0d exp v=1 c=0 insn=00100093 pc=8000000a cnt=2",
                        dequeueValid, dequeueCompressed, dequeueInsn, dequeuePc, entryCount); end
    deq1();
  endtask

  task automatic test_full_wrap();
    logic [15:0] lo;
    logic [15:0] hi;
    // Shift alignment by one so 32-bit pairs straddle entries 7/0.
    enq(2'd1, 32'h0000_0ffe, 32'h0000_4501, 1'b0, 1'b0, 4'h0);
    deq1();
    for (int k = 0; k < 4; k++) begin
      lo = 16'h0013 | (16'(k) << 8);
      hi = 16'ha000 + 16'(k);
      if (k == 3) begin
        vecs++; if (enqueueReady !== 1'b1) begin
          fails++; $display("FAIL full_ready_at6: got %b exp 1", enqueueReady); end
      end
      enq(2'd2, 32'h0000_1000 + 32'(4 * k), {hi, lo}, 1'b0, 1'b0, 4'h0);
    end
    vecs++; if ({entryCount, enqueueReady} !== {4'd8, 1'b0}) begin
      fails++; $display("FAIL full_state: got cnt=%0d r=%b exp cnt=8 r=0", entryCount, enqueueReady); end
    vecs++; if ({dequeueValid, dequeueInsn, dequeuePc} !== {1'b1, 32'ha000_0013, 32'h0000_1000}) begin
      fails++; $display("FAIL wrap_pair70: got v=%b insn=%h pc=%h exp v=1 insn=a0000013 pc=00001000", dequeueValid, dequeueInsn, dequeuePc); end
    deq1();
    vecs++; if ({entryCount, enqueueReady} !== {4'd6, 1'b1}) begin
      fails++; $display("FAIL after_one_deq: got cnt=%0d r=%b exp cnt=6 r=1", entryCount, enqueueReady); end
    enq(2'd2, 32'h0000_1010, 32'ha004_0413, 1'b0, 1'b0, 4'h0);
    vecs++; if (entryCount !== 4'd8) begin
      fails++; $display("FAIL refill: got cnt=%0d exp 8", entryCount); end
    dequeueReady = 1'b1;
    for (int k = 1; k < 5; k++) begin
      lo = 16'h0013 | (16'(k) << 8);
      hi = 16'ha000 + 16'(k);
      vecs++; if ({dequeueValid, dequeueCompressed, dequeueInsn, dequeuePc} !== {1'b1, 1'b0, hi, lo, 32'h0000_1000 + 32'(4 * k)}) begin
        fails++; $display("FAIL drain_beat%0d: got v=%b c=%b insn=%h pc=%h exp v=1 c=0 insn=%h%h pc=%h",
                          k, dequeueValid, dequeueCompressed, dequeueInsn, dequeuePc, hi, lo, 32'h0000_1000 + 32'(4 * k)); end
      tick();
    end
    dequeueReady = 1'b0;
    vecs++; if ({dequeueValid, entryCount} !== {1'b0, 4'd0}) begin
      fails++; $display("FAIL wrap_empty: got v=%b cnt=%0d exp v=0 cnt=0", dequeueValid, entryCount); end
  endtask

  task automatic test_back_to_back();
    enq(2'd2, 32'h0000_2000, 32'h4481_4401, 1'b0, 1'b0, 4'h0);
    // Enqueue two and dequeue one in the same cycle.
    enqueueValid = 1'b1; enqueueCount = 2'd2; enqueuePc = 32'h0000_2004; enqueueInsn = 32'h0010_0093;
    dequeueReady = 1'b1;
    tick();
    enqueueValid = 1'b0;
    vecs++; if ({entryCount, dequeueInsn, dequeuePc} !== {4'd3, 32'h0000_4481, 32'h0000_2002}) begin
      fails++; $display("FAIL b2b_mixed: got cnt=%0d insn=%h pc=%h exp cnt=3 insn=00004481 pc=00002002", entryCount, dequeueInsn, dequeuePc); end
    tick();
    vecs++; if ({entryCount, dequeueCompressed, dequeueInsn, dequeuePc} !== {4'd2, 1'b0, 32'h0010_0093, 32'h0000_2004}) begin
      fails++; $display("FAIL b2b_second: got cnt=%0d c=%b insn=%h pc=%h exp cnt=2 c=0 insn=00100093 pc=00002004",
                        entryCount, dequeueCompressed, dequeueInsn, dequeuePc); end
    tick();
    dequeueReady = 1'b0;
    vecs++; if ({dequeueValid, entryCount} !== {1'b0, 4'd0}) begin
      fails++; $display("FAIL b2b_empty: got v=%b cnt=%0d exp v=0 cnt=0", dequeueValid, entryCount); end
  endtask

  task automatic test_fault_irq();
    enq(2'd2, 32'h0000_3000, 32'h0010_0093, 1'b1, 1'b0, 4'h0);
    vecs++; if ({dequeueValid, dequeueCompressed, dequeueFault, dequeueInsn, entryCount} !== {1'b1, 1'b0, 1'b1, 32'h0000_0093, 4'd2}) begin
      fails++; $display("FAIL fault_head: got v=%b c=%b f=%b insn=%h cnt=%0d exp v=1 c=0 f=1 insn=00000093 cnt=2",
                        dequeueValid, dequeueCompressed, dequeueFault, dequeueInsn, entryCount); end
    deq1();
    vecs++; if ({entryCount, dequeueFault, dequeueCompressed, dequeueInsn, dequeuePc} !== {4'd1, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_3002}) begin
      fails++; $display("FAIL fault_lane1: got cnt=%0d f=%b c=%b insn=%h pc=%h exp cnt=1 f=1 c=1 insn=00000010 pc=00003002",
                        entryCount, dequeueFault, dequeueCompressed, dequeueInsn, dequeuePc); end
    deq1();
    enq(2'd2, 32'h0000_3004, 32'h0010_0093, 1'b0, 1'b1, 4'h7);
    vecs++; if ({dequeueInterruptValid, dequeueInterruptCode, dequeueCompressed, dequeueInsn} !== {1'b1, 4'h7, 1'b0, 32'h0000_0093}) begin
      fails++; $display("FAIL irq_lane0: got iv=%b code=%h c=%b insn=%h exp iv=1 code=7 c=0 insn=00000093",
                        dequeueInterruptValid, dequeueInterruptCode, dequeueCompressed, dequeueInsn); end
    deq1();
    vecs++; if ({dequeueValid, dequeueInterruptValid, dequeueInterruptCode} !== {1'b1, 1'b0, 4'h0}) begin
      fails++; $display("FAIL irq_lane1_untagged: got v=%b iv=%b code=%h exp v=1 iv=0 code=0", dequeueValid, dequeueInterruptValid, dequeueInterruptCode); end
    deq1();
    enq(2'd1, 32'h0000_3010, 32'h0000_0093, 1'b0, 1'b0, 4'h0);
    enq(2'd1, 32'h0000_3012, 32'h0000_0010, 1'b0, 1'b1, 4'h5);
    vecs++; if ({dequeueValid, dequeueInterruptValid, dequeueInterruptCode, dequeueFault, dequeueInsn} !== {1'b1, 1'b1, 4'h5, 1'b0, 32'h0010_0093}) begin
      fails++; $display("FAIL irq_upper_half: got v=%b iv=%b code=%h f=%b insn=%h exp v=1 iv=1 code=5 f=0 insn=00100093",
                        dequeueValid, dequeueInterruptValid, dequeueInterruptCode, dequeueFault, dequeueInsn); end
    deq1();
  endtask

  task automatic test_flush();
    enq(2'd2, 32'h0000_4000, 32'h4585_4505, 1'b0, 1'b0, 4'h0);
    enq(2'd2, 32'h0000_4004, 32'h4585_4505, 1'b0, 1'b0, 4'h0);
    enq(2'd1, 32'h0000_4008, 32'h0000_4505, 1'b0, 1'b0, 4'h0);
    vecs++; if (entryCount !== 4'd5) begin
      fails++; $display("FAIL flush_setup: got cnt=%0d exp 5", entryCount); end
    flush = 1'b1; enqueueValid = 1'b1; enqueueCount = 2'd2; enqueueInsn = 32'h4585_4505; dequeueReady = 1'b1;
    #1;
    vecs++; if (enqueueReady !== 1'b0) begin
      fails++; $display("FAIL flush_blocks_ready: got %b exp 0", enqueueReady); end
    tick();
    flush = 1'b0; enqueueValid = 1'b0; dequeueReady = 1'b0;
    vecs++; if ({entryCount, dequeueValid, dequeueInsn} !== {4'd0, 1'b0, 32'h0}) begin
      fails++; $display("FAIL flush_result: got cnt=%0d v=%b insn=%h exp cnt=0 v=0 insn=0", entryCount, dequeueValid, dequeueInsn); end
    enq(2'd2, 32'h0000_5000, 32'h4585_4505, 1'b0, 1'b0, 4'h0);
    vecs++; if ({dequeueValid, dequeueInsn, dequeuePc, entryCount} !== {1'b1, 32'h0000_4505, 32'h0000_5000, 4'd2}) begin
      fails++; $display("FAIL post_flush: got v=%b insn=%h pc=%h cnt=%0d exp v=1 insn=00004505 pc=00005000 cnt=2",
                        dequeueValid, dequeueInsn, dequeuePc, entryCount); end
  endtask

  task automatic test_async_reset();
    enqueueValid = 1'b1; enqueueCount = 2'd2; enqueuePc = 32'h0000_6000; enqueueInsn = 32'h4585_4505;
    #1 rst = 1'b1;
    #1;
    vecs++; if ({dequeueValid, enqueueReady, entryCount, dequeueInsn} !== {1'b0, 1'b1, 4'd0, 32'h0}) begin
      fails++; $display("FAIL async_reset: got v=%b r=%b cnt=%0d insn=%h exp v=0 r=1 cnt=0 insn=0",
                        dequeueValid, enqueueReady, entryCount, dequeueInsn); end
    enqueueValid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    enq(2'd2, 32'h0000_7000, 32'h4505_4585, 1'b0, 1'b0, 4'h0);
    vecs++; if ({dequeueValid, dequeueInsn, dequeuePc, entryCount} !== {1'b1, 32'h0000_4585, 32'h0000_7000, 4'd2}) begin
      fails++; $display("FAIL post_reset: got v=%b insn=%h pc=%h cnt=%0d exp v=1 insn=00004585 pc=00007000 cnt=2",
                        dequeueValid, dequeueInsn, dequeuePc, entryCount); end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; enqueueValid = 1'b0; enqueueCount = 2'd1; enqueuePc = 32'h0;
    enqueueInsn = 32'h0; enqueueFault = 1'b0; enqueueInterruptValid = 1'b0; enqueueInterruptCode = 4'h0;
    dequeueReady = 1'b0;
    #1 rst = 1'b1;
    #2;
    test_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    test_basic_32();
    test_rvc_pair();
    test_split_32();
    test_full_wrap();
    test_back_to_back();
    test_fault_irq();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
